// File: rtl/ntt_pkg.sv
// Shared defaults, state encoding and modular-arithmetic helpers for the iterative NTT engine.
package ntt_pkg;

    localparam int unsigned Q_DEFAULT = 3329;
    localparam int unsigned W_DEFAULT = 12;

    typedef logic [W_DEFAULT-1:0] coeff_t;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN,
        UNLOAD
    } state_t;

    // All operands are expected to be already reduced below q.
    function automatic logic [31:0] modadd(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] q);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q})
            s = s - {1'b0, q};
        return s[31:0];
    endfunction

    function automatic logic [31:0] modsub(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] q);
        logic [31:0] d;
        if (a >= b)
            d = a - b;
        else
            d = a + q - b;
        return d;
    endfunction

    function automatic logic [31:0] modmul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] q);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return 32'(p % {32'd0, q});
    endfunction

    function automatic logic [31:0] powmod(input logic [31:0] base, input logic [31:0] e,
                                           input logic [31:0] q);
        logic [31:0] acc;
        logic [31:0] b;
        acc = 32'd1;
        b   = base % q;
        for (int i = 0; i < 32; i++) begin
            if (e[i])
                acc = modmul(acc, b, q);
            b = modmul(b, b, q);
        end
        return acc;
    endfunction

    // Fermat inverse; q is prime.
    function automatic logic [31:0] modinv(input logic [31:0] a, input logic [31:0] q);
        return powmod(a, q - 32'd2, q);
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] x, input int bits);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < bits)
                y[i] = x[bits-1-i];
        end
        return y;
    endfunction

endpackage

// File: rtl/ntt_bf_core.sv
// Cooley-Tukey butterfly with runtime twiddle: u' = u + w*v, v' = u - w*v (mod Q).
// LAT register stages; the write-back addresses travel alongside the data.
module ntt_bf_core
    import ntt_pkg::*;
#(
    parameter int unsigned Q   = Q_DEFAULT,
    parameter int unsigned W   = W_DEFAULT,
    parameter int unsigned AW  = 3,
    parameter int unsigned LAT = 2
) (
    input  logic          clk,
    input  logic          r,
    input  logic          in_valid,
    input  logic [W-1:0]  in_u,
    input  logic [W-1:0]  in_v,
    input  logic [W-1:0]  in_w,
    input  logic [AW-1:0] in_addr_u,
    input  logic [AW-1:0] in_addr_v,
    output logic          out_valid,
    output logic [W-1:0]  out_u,
    output logic [W-1:0]  out_v,
    output logic [AW-1:0] out_addr_u,
    output logic [AW-1:0] out_addr_v
);

    localparam logic [31:0] QL = 32'(Q);

    logic [W-1:0]  prod;
    logic          vld_q  [LAT];
    logic [W-1:0]  u_q    [LAT];
    logic [W-1:0]  t_q    [LAT];
    logic [AW-1:0] au_q   [LAT];
    logic [AW-1:0] av_q   [LAT];

    // Multiply ahead of the first register, add/sub after the last one.
    assign prod = W'(modmul(32'(in_v), 32'(in_w), QL));

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            for (int i = 0; i < LAT; i++)
                vld_q[i] <= 1'b0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < LAT; i++)
                vld_q[i] <= vld_q[i-1];
        end
    end

    // NOTE: data-only pipeline/storage registers are left unreset; only the valid bits need it.
    always_ff @(posedge clk) begin
        u_q[0]  <= in_u;
        t_q[0]  <= prod;
        au_q[0] <= in_addr_u;
        av_q[0] <= in_addr_v;
        for (int i = 1; i < LAT; i++) begin
            u_q[i]  <= u_q[i-1];
            t_q[i]  <= t_q[i-1];
            au_q[i] <= au_q[i-1];
            av_q[i] <= av_q[i-1];
        end
    end

    assign out_valid  = vld_q[LAT-1];
    assign out_u      = W'(modadd(32'(u_q[LAT-1]), 32'(t_q[LAT-1]), QL));
    assign out_v      = W'(modsub(32'(u_q[LAT-1]), 32'(t_q[LAT-1]), QL));
    assign out_addr_u = au_q[LAT-1];
    assign out_addr_v = av_q[LAT-1];

endmodule

// File: rtl/ntt_iter_engine.sv
// Iterative in-place N-point NTT/iNTT over Z_q with streaming valid/ready load and unload.
// Input is stored bit-reversed, transformed by radix-2 DIT stages, and read out in natural order.
module ntt_iter_engine
    import ntt_pkg::*;
#(
    parameter int unsigned Q         = Q_DEFAULT,
    parameter int unsigned W         = W_DEFAULT,
    parameter int unsigned LOGN      = 3,
    parameter int unsigned OMEGA     = 749,
    parameter int unsigned BF_LAT    = 2,
    parameter int unsigned SCALE_INV = 1
) (
    input  logic         clk,
    input  logic         r,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int unsigned N         = 1 << LOGN;
    localparam int unsigned HALF      = N / 2;
    localparam logic [31:0] QL        = 32'(Q);
    localparam logic [31:0] OMEGA_INV = modinv(32'(OMEGA), QL);
    localparam logic [31:0] N_INV     = modinv(32'(N) % QL, QL);

    state_t          state;
    logic [LOGN-1:0] load_cnt;
    logic [LOGN-1:0] bf_cnt;
    logic [LOGN-1:0] out_idx;
    logic [3:0]      stage_cnt;
    logic [1:0]      drain_cnt;
    logic            inv_mode;

    logic [W-1:0]    store   [N];
    logic [W-1:0]    fwd_rom [N];
    logic [W-1:0]    inv_rom [N];

    // Twiddle tables hold OMEGA^k and OMEGA^-k for k = 0..N-1.
    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [31:0] FWD = powmod(32'(OMEGA), 32'(k), QL);
        localparam logic [31:0] INV = powmod(OMEGA_INV, 32'(k), QL);
        assign fwd_rom[k] = FWD[W-1:0];
        assign inv_rom[k] = INV[W-1:0];
    end

    logic            load_beat;
    logic [LOGN-1:0] load_addr;
    logic [W-1:0]    in_red;

    assign in_ready  = (state == LOAD);
    assign busy      = (state != LOAD);
    assign load_beat = in_valid && (state == LOAD);
    assign load_addr = LOGN'(bitrev(32'(load_cnt), LOGN));
    assign in_red    = (in_data >= W'(Q)) ? in_data - W'(Q) : in_data;

    logic            issue_valid;
    logic [LOGN-1:0] half_bit;
    logic [LOGN-1:0] j_idx;
    logic [LOGN-1:0] addr_u;
    logic [LOGN-1:0] addr_v;
    logic [LOGN-1:0] tw_idx;
    logic [W-1:0]    twiddle;

    assign issue_valid = (state == COMPUTE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        half_bit = '0;
        j_idx    = '0;
        addr_u   = '0;
        addr_v   = '0;
        tw_idx   = '0;
        twiddle  = '0;
        half_bit = LOGN'(1) << stage_cnt;
        j_idx    = bf_cnt & (half_bit - LOGN'(1));
        addr_u   = ((bf_cnt & ~(half_bit - LOGN'(1))) << 1) | j_idx;
        addr_v   = addr_u | half_bit;
        tw_idx   = j_idx << (LOGN - 1 - 32'(stage_cnt));
        twiddle  = inv_mode ? inv_rom[tw_idx] : fwd_rom[tw_idx];
    end

    logic            wb_valid;
    logic [W-1:0]    wb_u;
    logic [W-1:0]    wb_v;
    logic [LOGN-1:0] wb_addr_u;
    logic [LOGN-1:0] wb_addr_v;

    ntt_bf_core #(
        .Q   (Q),
        .W   (W),
        .AW  (LOGN),
        .LAT (BF_LAT)
    ) u_bf (
        .clk        (clk),
        .r          (r),
        .in_valid   (issue_valid),
        .in_u       (store[addr_u]),
        .in_v       (store[addr_v]),
        .in_w       (twiddle),
        .in_addr_u  (addr_u),
        .in_addr_v  (addr_v),
        .out_valid  (wb_valid),
        .out_u      (wb_u),
        .out_v      (wb_v),
        .out_addr_u (wb_addr_u),
        .out_addr_v (wb_addr_v)
    );

    // Load and write-back never overlap: the pipeline is empty whenever the FSM is in LOAD.
    always_ff @(posedge clk) begin
        if (load_beat)
            store[load_addr] <= in_red;
        if (wb_valid) begin
            store[wb_addr_u] <= wb_u;
            store[wb_addr_v] <= wb_v;
        end
    end

    logic [LOGN-1:0] rd_idx;
    logic [W-1:0]    rd_val;

    always_comb begin
        rd_idx = out_valid ? out_idx + LOGN'(1) : out_idx;
        rd_val = store[rd_idx];
        if (inv_mode && (SCALE_INV != 0))
            rd_val = W'(modmul(32'(store[rd_idx]), N_INV, QL));
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state     <= LOAD;
            load_cnt  <= '0;
            bf_cnt    <= '0;
            stage_cnt <= '0;
            drain_cnt <= '0;
            out_idx   <= '0;
            inv_mode  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (load_cnt == '0)
                            inv_mode <= in_mode;
                        if (load_cnt == LOGN'(N - 1)) begin
                            load_cnt  <= '0;
                            bf_cnt    <= '0;
                            stage_cnt <= '0;
                            state     <= COMPUTE;
                        end else begin
                            load_cnt <= load_cnt + LOGN'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (bf_cnt == LOGN'(HALF - 1)) begin
                        bf_cnt    <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        bf_cnt <= bf_cnt + LOGN'(1);
                    end
                end
                DRAIN: begin
                    // Wait out the butterfly latency so the next stage reads settled results.
                    if (drain_cnt == 2'(BF_LAT - 1)) begin
                        drain_cnt <= '0;
                        if (stage_cnt == 4'(LOGN - 1)) begin
                            stage_cnt <= '0;
                            out_idx   <= '0;
                            state     <= UNLOAD;
                        end else begin
                            stage_cnt <= stage_cnt + 4'd1;
                            state     <= COMPUTE;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                UNLOAD: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= rd_val;
                        out_last  <= (rd_idx == LOGN'(N - 1));
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_idx   <= '0;
                            state     <= LOAD;
                        end else begin
                            out_idx  <= rd_idx;
                            out_data <= rd_val;
                            out_last <= (rd_idx == LOGN'(N - 1));
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_iter_engine.sv
// Directed bench for ntt_iter_engine at default parameters (N=8, Q=3329, OMEGA=749).
module tb_ntt_iter_engine;

    localparam int N = 8;
    localparam int Q = 3329;
    localparam int LAT_EXP = 19;

    typedef int vec_t [N];

    logic        clk = 1'b0;
    logic        r;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_last;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ntt_iter_engine dut (
        .clk       (clk),
        .r         (r),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pw(input int b, input int e);
        longint acc = 1;
        for (int i = 0; i < e; i++)
            acc = (acc * b) % Q;
        return int'(acc);
    endfunction

    // Direct O(N^2) transform; the inverse uses 3289 = 749^-1 and scale 2913 = 8^-1.
    task automatic dft(input vec_t a, input bit inv, output vec_t y);
        longint acc;
        int root;
        root = inv ? 3289 : 749;
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int j = 0; j < N; j++)
                acc = (acc + longint'(a[j] % Q) * pw(root, (j * k) % N)) % Q;
            if (inv)
                acc = (acc * 2913) % Q;
            y[k] = int'(acc);
        end
    endtask

    // in_mode is flipped after beat 0 to confirm it is only sampled on the first beat.
    task automatic send(input string tag, input vec_t a, input bit mode);
        check({tag, "_ready"}, in_ready, 1);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = 12'(a[i]);
            in_mode  = (i == 0) ? mode : ~mode;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_mode  = 1'b0;
    endtask

    task automatic recv(input string tag, input vec_t exp, input bit toggle, input int exp_lat);
        int lat  = 0;
        int beat = 0;
        int cyc  = 0;
        bit rdy;
        out_ready = 1'b1;
        while (!out_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_valid"}, out_valid, 1);
        if (exp_lat > 0)
            check({tag, "_lat"}, lat, exp_lat);
        while (beat < N && cyc < 200) begin
            rdy       = toggle ? (cyc % 2 == 0) : 1'b1;
            out_ready = rdy;
            check($sformatf("%s_v%0d", tag, cyc), out_valid, 1);
            check($sformatf("%s_d%0d", tag, beat), out_data, exp[beat]);
            check($sformatf("%s_last%0d", tag, beat), out_last, (beat == N - 1) ? 1 : 0);
            check($sformatf("%s_inrdy%0d", tag, cyc), in_ready, 0);
            if (out_valid && rdy)
                beat++;
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        check({tag, "_beats"}, beat, N);
        check({tag, "_cycles"}, cyc, toggle ? 2 * N - 1 : N);
        check({tag, "_done_valid"}, out_valid, 0);
        check({tag, "_done_ready"}, in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t a;
        vec_t e;
        vec_t ar;
        vec_t y;
        int   seen;

        r         = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        r = 1'b0;
        @(posedge clk); #1;

        a = '{1, 0, 0, 0, 0, 0, 0, 0};
        e = '{1, 1, 1, 1, 1, 1, 1, 1};
        send("imp", a, 1'b0);
        check("imp_busy", busy, 1);
        recv("imp", e, 1'b0, LAT_EXP);

        a = '{0, 1, 0, 0, 0, 0, 0, 0};
        e = '{1, 749, 1729, 40, 3328, 2580, 1600, 3289};
        send("x1", a, 1'b0);
        recv("x1", e, 1'b0, LAT_EXP);
        send("x1inv", e, 1'b1);
        recv("x1inv", a, 1'b0, LAT_EXP);

        a = '{1, 1, 1, 1, 1, 1, 1, 1};
        e = '{1, 0, 0, 0, 0, 0, 0, 0};
        send("ones", a, 1'b1);
        recv("ones_inv", e, 1'b0, LAT_EXP);

        a = '{4095, 0, 0, 0, 0, 0, 0, 0};
        e = '{766, 766, 766, 766, 766, 766, 766, 766};
        send("big", a, 1'b0);
        recv("big", e, 1'b0, LAT_EXP);

        a = '{0, 0, 1, 0, 0, 0, 0, 0};
        e = '{1, 1729, 3328, 1600, 1, 1729, 3328, 1600};
        send("stall", a, 1'b0);
        recv("stall", e, 1'b1, LAT_EXP);

        a = '{5, 6, 7, 8, 9, 10, 11, 12};
        send("abort", a, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_busy", busy, 1);
        r = 1'b1;
        @(posedge clk); #1;
        r = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy_low", busy, 0);
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            seen += int'(out_valid);
        end
        check("abort_no_output", seen, 0);
        a = '{0, 1, 0, 0, 0, 0, 0, 0};
        e = '{1, 749, 1729, 40, 3328, 2580, 1600, 3289};
        send("after", a, 1'b0);
        recv("after", e, 1'b0, LAT_EXP);

        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < N; i++) begin
                a[i]  = int'($urandom_range(0, 4095));
                ar[i] = a[i] % Q;
            end
            dft(a, 1'b0, y);
            send($sformatf("rnd%0d_f", t), a, 1'b0);
            recv($sformatf("rnd%0d_f", t), y, 1'b0, LAT_EXP);
            send($sformatf("rnd%0d_i", t), y, 1'b1);
            recv($sformatf("rnd%0d_i", t), ar, t[0], LAT_EXP);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
